// File: rtl/mod_sync_pkg.sv
// mod_sync_pkg
// Shared types and default widths for the multi-channel modulation sync timer.
//   state_e      : per-channel sequencing state (IDLE / ARMED / RUN)
//   CYCLE_W_DEF  : default width of the cycle config and the sample index
//   DIV_W_DEF    : default width of the divider config and the divider counter
package mod_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int CYCLE_W_DEF = 16;
    localparam int DIV_W_DEF   = 16;

endpackage

// File: rtl/mod_sync_ch.sv
// mod_sync_ch
// One channel of the sync timer: divides the shared reference tick into a
// sample clock and runs a wrapping sample index, realigned by SYNC on request.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   ref_tick    : one-cycle reference tick
//   sync        : one-cycle global sync pulse
//   en          : channel enable (level)
//   init        : realign request (one-cycle pulse)
//   cycle, div  : live config, captured into shadows at wrap or realign
//   idx         : registered sample index
//   idx_valid   : one-cycle strobe when idx updates
//   wrap        : one-cycle strobe when idx returns to 0
//   state       : current FSM state (debug / RUNNING derivation)
//
// Handshake: there is no back-pressure. ref_tick, sync and init are
// single-cycle qualifiers sampled on the rising edge of CLK; idx_valid and wrap
// are single-cycle strobes the consumer must take in the cycle they appear.
module mod_sync_ch
    import mod_sync_pkg::*;
#(
    parameter int CYCLE_W = CYCLE_W_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               ref_tick,
    input  logic               sync,
    input  logic               en,
    input  logic               init,
    input  logic [CYCLE_W-1:0] cycle,
    input  logic [DIV_W-1:0]   div,
    output logic [CYCLE_W-1:0] idx,
    output logic               idx_valid,
    output logic               wrap,
    output state_e             state
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CYCLE_W-1:0] idx_q, idx_d;
    logic [CYCLE_W-1:0] cyc_s_q, cyc_s_d;
    logic [DIV_W-1:0]   div_s_q, div_s_d;
    logic               pend_q, pend_d;
    logic               idx_valid_q, idx_valid_d;
    logic               wrap_q, wrap_d;
    logic               align;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        idx_d       = idx_q;
        cyc_s_d     = cyc_s_q;
        div_s_d     = div_s_q;
        pend_d      = pend_q;
        idx_valid_d = 1'b0;
        wrap_d      = 1'b0;
        align       = 1'b0;

        if (!en) begin
            // Disable wins over everything, including a same-cycle SYNC.
            state_d   = ST_IDLE;
            div_cnt_d = '0;
            idx_d     = '0;
            pend_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    div_cnt_d = '0;
                    idx_d     = '0;
                    pend_d    = 1'b0;
                    // INIT together with SYNC arms and aligns in one step.
                    if (init && sync) align = 1'b1;
                    else if (init)    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    div_cnt_d = '0;
                    idx_d     = '0;
                    if (sync) align = 1'b1;
                end
                ST_RUN: begin
                    if (init) pend_d = 1'b1;
                    if (sync && (pend_q || init)) begin
                        // Realign drops a coincident tick.
                        align = 1'b1;
                    end else if (ref_tick) begin
                        if (div_cnt_q == div_s_q) begin
                            div_cnt_d   = '0;
                            idx_valid_d = 1'b1;
                            if (idx_q == cyc_s_q) begin
                                idx_d   = '0;
                                wrap_d  = 1'b1;
                                cyc_s_d = cycle;
                                div_s_d = div;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            div_cnt_d = div_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (align) begin
                state_d     = ST_RUN;
                cyc_s_d     = cycle;
                div_s_d     = div;
                div_cnt_d   = '0;
                idx_d       = '0;
                pend_d      = 1'b0;
                idx_valid_d = 1'b1;
                wrap_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            idx_q       <= '0;
            cyc_s_q     <= '0;
            div_s_q     <= '0;
            pend_q      <= 1'b0;
            idx_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            cyc_s_q     <= cyc_s_d;
            div_s_q     <= div_s_d;
            pend_q      <= pend_d;
            idx_valid_q <= idx_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign wrap      = wrap_q;
    assign state     = state_q;

endmodule

// File: rtl/mod_sync_timer.sv
// mod_sync_timer
// N_CH independent modulation sync channels sharing one reference tick and one
// global SYNC. Per-channel buses are packed with channel 0 in the low slice.
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   REF_CLK_TICK  : shared reference tick
//   SYNC          : shared global sync pulse
//   EN, INIT      : per-channel enable level / realign request
//   CYCLE, DIV    : per-channel last index / divider
//   IDX           : per-channel sample index
//   IDX_VALID     : per-channel index update strobe
//   WRAP          : per-channel wrap strobe
//   RUNNING       : per-channel RUN state indicator
module mod_sync_timer
    import mod_sync_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CYCLE_W = CYCLE_W_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    REF_CLK_TICK,
    input  logic                    SYNC,
    input  logic [N_CH-1:0]         EN,
    input  logic [N_CH-1:0]         INIT,
    input  logic [N_CH*CYCLE_W-1:0] CYCLE,
    input  logic [N_CH*DIV_W-1:0]   DIV,
    output logic [N_CH*CYCLE_W-1:0] IDX,
    output logic [N_CH-1:0]         IDX_VALID,
    output logic [N_CH-1:0]         WRAP,
    output logic [N_CH-1:0]         RUNNING
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_e ch_state;

        mod_sync_ch #(
            .CYCLE_W(CYCLE_W),
            .DIV_W  (DIV_W)
        ) u_ch (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .ref_tick (REF_CLK_TICK),
            .sync     (SYNC),
            .en       (EN[g]),
            .init     (INIT[g]),
            .cycle    (CYCLE[g*CYCLE_W +: CYCLE_W]),
            .div      (DIV[g*DIV_W +: DIV_W]),
            .idx      (IDX[g*CYCLE_W +: CYCLE_W]),
            .idx_valid(IDX_VALID[g]),
            .wrap     (WRAP[g]),
            .state    (ch_state)
        );

        // Decoded straight from the state register, so still flop-driven.
        assign RUNNING[g] = (ch_state == ST_RUN);
    end

endmodule
